keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter: DWELL_CYCLES, default 3, cycles each column is driven during scanning (minimum 3).
REQ-002 Parameter: DEBOUNCE_CYCLES, default 3, consecutive matching row samples required to accept a press (1-15).
REQ-003 Parameter: RELEASE_CYCLES, default 2, consecutive all-zero row samples required to accept a release (1-15).
REQ-004 Port: Clock_10ms  input  1  sole clock; all logic on posedge.
REQ-005 Port: nReset  input  1  synchronous, active-low reset.
REQ-006 Port: rowIn  input  4  raw keypad row sense lines, active-high, asynchronous to Clock_10ms.
REQ-007 Port: Column  output  4  one-hot active-high column drive; also the reported key column.
REQ-008 Port: row  output  4  latched one-hot row of the accepted key; 0 when no key is accepted.
REQ-009 Port: keypadValid  output  1  level; high while an accepted key is held.
REQ-010 Port: validHigh  output  1  single-cycle pulse on each newly accepted press.

Function
REQ-011 rowIn SHALL pass through a 2-flop synchronizer (rowSync), with both flops reset to 0; all decisions SHALL use rowSync only.
REQ-012 States SHALL be SCAN, DEBOUNCE, HELD and RELEASE, with reset state SCAN.
REQ-013 SCAN: Column SHALL be held for DWELL_CYCLES cycles, then rotate 0001->0010->0100->1000->0001.
REQ-014 SCAN: rowSync SHALL be sampled only in the last dwell cycle of each column.
REQ-015 SCAN sample rules: one-hot -> latch the sample into an internal capture register, freeze Column, clear the counter, go to DEBOUNCE; zero or multi-bit -> continue scanning.
REQ-016 DEBOUNCE: each cycle, rowSync == capture increments the counter, and any mismatch returns to SCAN with the counter cleared.
REQ-017 DEBOUNCE exit on mismatch: Column SHALL advance to the next column and start a fresh dwell.
REQ-018 DEBOUNCE: when the counter reaches DEBOUNCE_CYCLES, the block SHALL go to HELD and copy capture to row.
REQ-019 HELD first cycle: validHigh=1 and keypadValid=1; validHigh=0 on every other cycle.
REQ-020 HELD/RELEASE: Column and row SHALL stay frozen and keypadValid SHALL stay high.
REQ-021 HELD: rowSync == 0 SHALL go to RELEASE with the counter cleared; any non-zero rowSync SHALL stay in HELD (no re-pulse).
REQ-022 RELEASE: rowSync == 0 increments the counter; non-zero rowSync returns to HELD without a validHigh pulse.
REQ-023 RELEASE: when the counter reaches RELEASE_CYCLES, the block SHALL go to SCAN.
REQ-024 RELEASE exit: in the SCAN entry cycle, row=0 and keypadValid=0, and Column SHALL advance to the next column with a fresh dwell.
REQ-025 Debounce and release counters SHALL be 4 bits and SHALL saturate, never wrapping.
REQ-026 A second key pressed while in HELD SHALL be ignored until full release; no rollover and no queuing.
REQ-027 The block SHALL produce at most one validHigh pulse per press/release cycle.

Reset
REQ-028 With nReset low at a posedge, the block SHALL enter SCAN with Column=0001, row=0000, keypadValid=0, validHigh=0, counters=0, dwell=0 and synchronizer=0.
REQ-029 Reset asserted mid-DEBOUNCE, mid-HELD or mid-RELEASE SHALL abort the operation immediately with no validHigh pulse.
REQ-030 A key still held after reset deassertion SHALL be re-detected as a new press, with a new validHigh pulse.

Verification
REQ-031 Default parameters; the bench keypad model drives rowIn=0010 whenever Column=0100; nReset released before cycle 0 -> validHigh=1 in cycle 12 only; row=0010, Column=0100 and keypadValid=1 from cycle 12.
REQ-032 Bounce: rowIn toggles 0010/0000 on alternate cycles during DEBOUNCE -> no validHigh; Column advances to 1000 and scanning resumes.
REQ-033 Release: key from REQ-031 released at cycle 20 -> keypadValid falls and row=0000 exactly 5 cycles later (2 synchronizer + 1 HELD->RELEASE + 2 release); Column then 1000.
REQ-034 Release glitch: during RELEASE a 1-cycle rowSync=0010 -> returns to HELD; keypadValid stays 1; no second validHigh.
REQ-035 Multi-key: rowIn=0110 on column 0001 -> never accepted, Column keeps rotating; separately, a second key in another column while HELD -> no pulse, row unchanged.
REQ-036 Reset mid-HELD: nReset low for 1 cycle while the key stays held -> outputs return to reset values, and validHigh pulses again after the REQ-031 timing relative to the deassertion cycle.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: rotating column drive, synchronized row sensing,
// press debounce, release qualification and a one-cycle new-key pulse.
module keypad_scan #(
    parameter int DWELL_CYCLES    = 3,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int RELEASE_CYCLES  = 2
) (
    input  logic       Clock_10ms,
    input  logic       nReset,
    input  logic [3:0] rowIn,
    output logic [3:0] Column,
    output logic [3:0] row,
    output logic       keypadValid,
    output logic       validHigh
);

    localparam int DW_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 2;
    localparam logic [DW_W-1:0] LAST_DWELL = DW_W'(DWELL_CYCLES - 1);
    localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_CYCLES);
    localparam logic [3:0] REL_TARGET = 4'(RELEASE_CYCLES);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    state_t          state_r;
    state_t          state_s;
    logic [3:0]      row_meta_r;
    logic [3:0]      row_sync_r;
    logic [DW_W-1:0] dwell_r;
    logic [DW_W-1:0] dwell_s;
    logic [3:0]      cnt_r;
    logic [3:0]      cnt_s;
    logic [3:0]      capture_r;
    logic [3:0]      capture_s;
    logic [3:0]      column_s;
    logic [3:0]      row_s;
    logic            valid_s;
    logic            pulse_s;

    logic            sample_s;
    logic            match_s;
    logic            zero_s;
    logic [3:0]      cnt_inc_s;
    logic [3:0]      col_next_s;

    // Saturating counter keeps the compare targets reachable without wrap.
    assign sample_s   = (dwell_r == LAST_DWELL);
    assign match_s    = (row_sync_r == capture_r);
    assign zero_s     = (row_sync_r == 4'b0000);
    assign cnt_inc_s  = (cnt_r == 4'hF) ? cnt_r : (cnt_r + 4'd1);
    assign col_next_s = {Column[2:0], Column[3]};

    // Two-flop synchronizer for the asynchronous row sense lines.
    always_ff @(posedge Clock_10ms) begin
        if (!nReset) begin
            row_meta_r <= 4'b0000;
            row_sync_r <= 4'b0000;
        end else begin
            row_meta_r <= rowIn;
            row_sync_r <= row_meta_r;
        end
    end

    // State register.
    always_ff @(posedge Clock_10ms) begin
        if (!nReset) begin
            state_r <= SCAN;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decision from the synchronized rows.
    always_comb begin
        state_s = state_r;
        case (state_r)
            SCAN: begin
                if (sample_s && is_one_hot(row_sync_r)) begin
                    state_s = DEBOUNCE;
                end else begin
                    state_s = SCAN;
                end
            end
            DEBOUNCE: begin
                if (!match_s) begin
                    state_s = SCAN;
                end else if (cnt_inc_s == DEB_TARGET) begin
                    state_s = HELD;
                end else begin
                    state_s = DEBOUNCE;
                end
            end
            HELD: begin
                if (zero_s) begin
                    state_s = RELEASE;
                end else begin
                    state_s = HELD;
                end
            end
            RELEASE: begin
                if (!zero_s) begin
                    state_s = HELD;
                end else if (cnt_inc_s == REL_TARGET) begin
                    state_s = SCAN;
                end else begin
                    state_s = RELEASE;
                end
            end
            default: begin
                state_s = SCAN;
            end
        endcase
    end

    // Next values of the column drive, counters, capture and outputs.
    always_comb begin
        column_s  = Column;
        dwell_s   = dwell_r;
        cnt_s     = cnt_r;
        capture_s = capture_r;
        row_s     = row;
        valid_s   = keypadValid;
        pulse_s   = 1'b0;
        case (state_r)
            SCAN: begin
                if (!sample_s) begin
                    dwell_s = dwell_r + DW_W'(1);
                end else if (is_one_hot(row_sync_r)) begin
                    capture_s = row_sync_r;
                    cnt_s     = 4'd0;
                    dwell_s   = {DW_W{1'b0}};
                end else begin
                    column_s = col_next_s;
                    dwell_s  = {DW_W{1'b0}};
                end
            end
            DEBOUNCE: begin
                if (!match_s) begin
                    cnt_s    = 4'd0;
                    column_s = col_next_s;
                    dwell_s  = {DW_W{1'b0}};
                end else if (cnt_inc_s == DEB_TARGET) begin
                    cnt_s   = cnt_inc_s;
                    row_s   = capture_r;
                    valid_s = 1'b1;
                    pulse_s = 1'b1;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            HELD: begin
                if (zero_s) begin
                    cnt_s = 4'd0;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            RELEASE: begin
                if (!zero_s) begin
                    cnt_s = cnt_r;
                end else if (cnt_inc_s == REL_TARGET) begin
                    cnt_s    = 4'd0;
                    row_s    = 4'b0000;
                    valid_s  = 1'b0;
                    column_s = col_next_s;
                    dwell_s  = {DW_W{1'b0}};
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            default: begin
                column_s = 4'b0001;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge Clock_10ms) begin
        if (!nReset) begin
            Column      <= 4'b0001;
            dwell_r     <= {DW_W{1'b0}};
            cnt_r       <= 4'd0;
            capture_r   <= 4'b0000;
            row         <= 4'b0000;
            keypadValid <= 1'b0;
            validHigh   <= 1'b0;
        end else begin
            Column      <= column_s;
            dwell_r     <= dwell_s;
            cnt_r       <= cnt_s;
            capture_r   <= capture_s;
            row         <= row_s;
            keypadValid <= valid_s;
            validHigh   <= pulse_s;
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Randomized and directed bench for keypad_scan against a scan-timeline model.
module tb_keypad_scan;

    localparam int DW = 3;
    localparam int DB = 3;
    localparam int RC = 2;

    logic       clk = 1'b0;
    logic       nReset;
    logic [3:0] rowIn;
    logic [3:0] Column;
    logic [3:0] row;
    logic       keypadValid;
    logic       validHigh;

    keypad_scan #(
        .DWELL_CYCLES    (DW),
        .DEBOUNCE_CYCLES (DB),
        .RELEASE_CYCLES  (RC)
    ) dut (
        .Clock_10ms  (clk),
        .nReset      (nReset),
        .rowIn       (rowIn),
        .Column      (Column),
        .row         (row),
        .keypadValid (keypadValid),
        .validHigh   (validHigh)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          pulses = 0;
    bit          chk_en = 1'b0;
    bit          bounce = 1'b0;
    logic [15:0] keys = 16'h0000;
    logic [3:0]  inj = 4'b0000;

    // Model: a global scan timeline (tick) that freezes while a key is tracked.
    int          m_mode = 0;
    int          m_tick = 0;
    int          m_run = 0;
    logic [3:0]  m_cap = 4'b0000;
    logic [3:0]  m_row = 4'b0000;
    logic        m_valid = 1'b0;
    logic        m_pulse = 1'b0;
    logic [3:0]  s_a = 4'b0000;
    logic [3:0]  s_b = 4'b0000;

    function automatic logic [3:0] m_col(input int t);
        logic [3:0] one;
        one = 4'b0001;
        return one << ((t / DW) % 4);
    endfunction

    function automatic logic [3:0] pad(input logic [15:0] k, input logic [3:0] col);
        logic [3:0] r;
        r = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            if (col[c]) r = r | k[c*4 +: 4];
        end
        return r;
    endfunction

    task automatic model_step();
        logic [3:0] rs;
        rs = s_b;
        if (!nReset) begin
            m_mode = 0; m_tick = 0; m_run = 0; m_cap = 4'b0000;
            m_row = 4'b0000; m_valid = 1'b0; m_pulse = 1'b0;
            s_a = 4'b0000; s_b = 4'b0000;
        end else begin
            m_pulse = 1'b0;
            case (m_mode)
                0: begin
                    if ((m_tick % DW == DW - 1) && ($countones(rs) == 1)) begin
                        m_cap = rs; m_run = 0; m_mode = 1;
                    end else begin
                        m_tick++;
                    end
                end
                1: begin
                    if (rs == m_cap) begin
                        m_run++;
                        if (m_run == DB) begin
                            m_mode = 2; m_row = m_cap; m_valid = 1'b1; m_pulse = 1'b1;
                        end
                    end else begin
                        m_mode = 0; m_run = 0; m_tick = (m_tick / DW + 1) * DW;
                    end
                end
                2: begin
                    if (rs == 4'b0000) begin
                        m_mode = 3; m_run = 0;
                    end
                end
                default: begin
                    if (rs != 4'b0000) begin
                        m_mode = 2;
                    end else begin
                        m_run++;
                        if (m_run == RC) begin
                            m_mode = 0; m_row = 4'b0000; m_valid = 1'b0;
                            m_tick = (m_tick / DW + 1) * DW;
                        end
                    end
                end
            endcase
            s_b = s_a;
            s_a = rowIn;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic compare_model();
        logic [9:0] act;
        logic [9:0] exp;
        act = {Column, row, keypadValid, validHigh};
        exp = {m_col(m_tick), m_row, m_valid, m_pulse};
        check("model", 32'(act), 32'(exp));
        if (validHigh === 1'b1) pulses++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        if (chk_en) compare_model();
        rowIn = pad(keys, Column);
        if (bounce && cyc[0]) rowIn = 4'b0000;
        rowIn = rowIn ^ inj;
        inj = 4'b0000;
    endtask

    task automatic do_reset(input int n);
        nReset = 1'b0;
        repeat (n) tick();
        nReset = 1'b1;
        cyc = 0;
        pulses = 0;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        nReset = 1'b0;
        rowIn = 4'b0000;
        do_reset(3);
        chk_en = 1'b1;
        check("reset_outputs", 32'({Column, row, keypadValid, validHigh}), 32'({4'b0001, 4'b0000, 1'b0, 1'b0}));

        // Basic press on column 2, row 1, then release at cycle 20.
        keys = 16'h0200;
        run_to(11);
        check("pulse_early", 32'(validHigh), 32'(1'b0));
        run_to(12);
        check("pulse_c12", 32'(validHigh), 32'(1'b1));
        check("held_out_c12", 32'({Column, row, keypadValid}), 32'({4'b0100, 4'b0010, 1'b1}));
        run_to(13);
        check("pulse_single", 32'(validHigh), 32'(1'b0));
        run_to(19);
        keys = 16'h0000;
        run_to(24);
        check("still_valid_c24", 32'(keypadValid), 32'(1'b1));
        run_to(25);
        check("release_c25", 32'({Column, row, keypadValid}), 32'({4'b1000, 4'b0000, 1'b0}));

        // Release glitch re-enters HELD without a second pulse.
        do_reset(1);
        keys = 16'h0200;
        run_to(19);
        keys = 16'h0000;
        run_to(21);
        inj = 4'b0010;
        run_to(25);
        check("glitch_valid_c25", 32'(keypadValid), 32'(1'b1));
        run_to(27);
        check("glitch_valid_c27", 32'(keypadValid), 32'(1'b1));
        run_to(28);
        check("glitch_release_c28", 32'(keypadValid), 32'(1'b0));
        check("glitch_one_pulse", 32'(pulses), 32'd1);

        // Bouncing contact never accepted.
        do_reset(1);
        keys = 16'h0200;
        bounce = 1'b1;
        run_to(10);
        check("bounce_col_c10", 32'({Column, keypadValid}), 32'({4'b1000, 1'b0}));
        run_to(50);
        check("bounce_no_pulse", 32'(pulses), 32'd0);
        bounce = 1'b0;

        // Two rows in one column are rejected and scanning continues.
        do_reset(1);
        keys = 16'h0006;
        run_to(3);
        check("multi_rotate_c3", 32'(Column), 32'(4'b0010));
        run_to(40);
        check("multi_no_pulse", 32'({pulses[3:0], keypadValid}), 32'({4'd0, 1'b0}));

        // Second key while HELD is ignored.
        do_reset(1);
        keys = 16'h0200;
        run_to(14);
        keys = 16'h1200;
        run_to(40);
        check("second_key_row", 32'({row, keypadValid}), 32'({4'b0010, 1'b1}));
        check("second_key_pulses", 32'(pulses), 32'd1);

        // Reset while HELD aborts, then the held key is found again.
        keys = 16'h0200;
        nReset = 1'b0;
        tick();
        check("midheld_reset", 32'({Column, row, keypadValid, validHigh}), 32'({4'b0001, 4'b0000, 1'b0, 1'b0}));
        nReset = 1'b1;
        cyc = 0;
        pulses = 0;
        run_to(11);
        check("redetect_c11", 32'(validHigh), 32'(1'b0));
        run_to(12);
        check("redetect_c12", 32'({validHigh, row, Column}), 32'({1'b1, 4'b0010, 4'b0100}));

        // Random keys, noise glitches and occasional resets.
        keys = 16'h0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) keys[$urandom_range(0, 15)] ^= 1'b1;
            if ($urandom_range(0, 24) == 0) inj = 4'($urandom_range(0, 15));
            nReset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
